// File: rtl/gate_bist_if.sv
// Host/gate-side bundle for the gate BIST controller.
// master = environment (host + gate model), slave = controller.
interface gate_bist_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             gate_a;
  logic             gate_b;
  logic             gate_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             fail_valid;
  logic [1:0]       fail_vec;

  modport master (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/gate_bist_controller.sv
// BIST sequencer for a 2-input gate: sweeps {a,b} = 00..11, samples gate_y after a
// settle time and scores it against TRUTH_TABLE.
//
// state  | meaning
// IDLE   | drives low, waiting for start
// SETTLE | vector held, settle timer counting down; gate_y scored on terminal count
// CHECK  | vector held one more cycle, then advance to the next vector / pass
// DONE   | done pulse and pass reported with the final vector still held; drives drop on exit
module gate_bist_controller #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.slave  bus
);

  localparam int TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       vec;
  logic [PC_W-1:0]  pass_cnt;
  logic [TMR_W-1:0] tmr;
  logic             gate_a_q;
  logic             gate_b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_q;
  logic             fail_valid_q;
  logic [1:0]       fail_vec_q;

  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] err_next;
  logic [1:0]       vec_next;

  assign mismatch = (bus.gate_y != TRUTH_TABLE[vec]);
  assign last_vec = (vec == 2'b11) && (pass_cnt == PC_LAST);
  assign vec_next = vec + 2'd1;
  // Saturate rather than wrap so a heavily broken gate never reads as clean.
  assign err_next = (mismatch && (err_q != {CNT_W{1'b1}})) ? err_q + CNT_W'(1) : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      vec          <= 2'b00;
      pass_cnt     <= '0;
      tmr          <= '0;
      gate_a_q     <= 1'b0;
      gate_b_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
    end else begin
      done_q <= 1'b0;
      if ((state != S_IDLE) && bus.abort) begin
        state    <= S_IDLE;
        gate_a_q <= 1'b0;
        gate_b_q <= 1'b0;
        busy_q   <= 1'b0;
        pass_q   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            if (bus.start) begin
              pass_q       <= 1'b0;
              err_q        <= '0;
              fail_valid_q <= 1'b0;
              fail_vec_q   <= 2'b00;
              vec          <= 2'b00;
              pass_cnt     <= '0;
              tmr          <= TMR_LOAD;
              busy_q       <= 1'b1;
              state        <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (tmr == '0) begin
              err_q <= err_next;
              if (mismatch && !fail_valid_q) begin
                fail_valid_q <= 1'b1;
                fail_vec_q   <= vec;
              end
              if (last_vec) begin
                done_q <= 1'b1;
                pass_q <= (err_next == '0);
                state  <= S_DONE;
              end else begin
                state <= S_CHECK;
              end
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          S_CHECK: begin
            if (vec == 2'b11) begin
              pass_cnt <= pass_cnt + PC_W'(1);
            end
            vec      <= vec_next;
            gate_a_q <= vec_next[1];
            gate_b_q <= vec_next[0];
            tmr      <= TMR_LOAD;
            state    <= S_SETTLE;
          end
          S_DONE: begin
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.gate_a     = gate_a_q;
  assign bus.gate_b     = gate_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule
